// File: rtl/uart_word_loader_if.sv
// Byte-in / word-out bundle between uart_rx, the word loader and the memory write port.
// master drives bytes and clear; slave (the loader) returns the assembled word and status.
interface uart_word_loader_if #(
  parameter int BYTES_PER_WORD = 2,
  parameter int ADDR_WIDTH     = 16
);
  localparam int WORD_WIDTH = 8 * BYTES_PER_WORD;

  logic                  clear;
  logic                  byte_ready;
  logic [7:0]            byte_in;
  logic                  word_ready;
  logic [WORD_WIDTH-1:0] word;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [ADDR_WIDTH:0]   word_count;
  logic [15:0]           checksum;
  logic                  busy;
  logic                  full;
  logic                  timeout_err;
  logic                  overflow_err;

  modport master (
    output clear, byte_ready, byte_in,
    input  word_ready, word, word_addr, word_count, checksum,
           busy, full, timeout_err, overflow_err
  );

  modport slave (
    input  clear, byte_ready, byte_in,
    output word_ready, word, word_addr, word_count, checksum,
           busy, full, timeout_err, overflow_err
  );
endinterface

// File: rtl/uart_word_loader.sv
// Packs received UART bytes into words with sequential load addresses, an inter-byte
// timeout that drops broken partial words, a capacity limit and a running byte checksum.
module uart_word_loader #(
  parameter int BYTES_PER_WORD = 2,
  parameter bit LSB_FIRST      = 1'b1,
  parameter int ADDR_WIDTH     = 16,
  parameter int MAX_WORDS      = 1024,
  parameter int TIMEOUT_CYCLES = 500000
) (
  input  logic              clk_50M,
  input  logic              rst,
  uart_word_loader_if.slave bus
);
  localparam int WORD_WIDTH = 8 * BYTES_PER_WORD;
  // A one-byte word still needs a 1-bit index so the vector is never zero width.
  localparam int IDX_W      = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int CNT_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0]    EXPIRE_CNT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] MAX_COUNT  = (ADDR_WIDTH + 1)'(MAX_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_FULL
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      byte_idx;
  logic [WORD_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      idle_cnt;

  logic [WORD_WIDTH-1:0] asm_word;
  logic [15:0]           asm_sum;
  logic [ADDR_WIDTH:0]   next_count;

  // Partial word with the incoming byte dropped into its slot, and that word's byte sum.
  always_comb begin
    asm_word = shreg;
    if (LSB_FIRST) asm_word[8*int'(byte_idx) +: 8] = bus.byte_in;
    else           asm_word[8*(BYTES_PER_WORD-1-int'(byte_idx)) +: 8] = bus.byte_in;
    asm_sum = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) asm_sum = asm_sum + 16'(asm_word[8*i +: 8]);
    next_count = bus.word_count + (ADDR_WIDTH + 1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values and ordering inside the block does not matter.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      byte_idx         <= '0;
      shreg            <= '0;
      idle_cnt         <= '0;
      bus.word_ready   <= 1'b0;
      bus.word         <= '0;
      bus.word_addr    <= '0;
      bus.word_count   <= '0;
      bus.checksum     <= '0;
      bus.busy         <= 1'b0;
      bus.full         <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.overflow_err <= 1'b0;
    end else if (bus.clear) begin
      // clear outranks a simultaneous byte: the byte is dropped.
      state            <= S_IDLE;
      byte_idx         <= '0;
      shreg            <= '0;
      idle_cnt         <= '0;
      bus.word_ready   <= 1'b0;
      bus.word         <= '0;
      bus.word_addr    <= '0;
      bus.word_count   <= '0;
      bus.checksum     <= '0;
      bus.busy         <= 1'b0;
      bus.full         <= 1'b0;
      bus.timeout_err  <= 1'b0;
      bus.overflow_err <= 1'b0;
    end else begin
      bus.word_ready <= 1'b0;
      case (state)
        S_IDLE, S_ASSEMBLE: begin
          if (bus.byte_ready) begin
            idle_cnt <= '0;
            if (byte_idx == LAST_IDX) begin
              bus.word_ready <= 1'b1;
              bus.word       <= asm_word;
              bus.word_addr  <= bus.word_count[ADDR_WIDTH-1:0];
              bus.word_count <= next_count;
              bus.checksum   <= bus.checksum + asm_sum;
              bus.busy       <= 1'b0;
              byte_idx       <= '0;
              shreg          <= '0;
              if (next_count == MAX_COUNT) begin
                bus.full <= 1'b1;
                state    <= S_FULL;
              end else begin
                state    <= S_IDLE;
              end
            end else begin
              shreg    <= asm_word;
              byte_idx <= byte_idx + IDX_W'(1);
              bus.busy <= 1'b1;
              state    <= S_ASSEMBLE;
            end
          end else if (state == S_ASSEMBLE) begin
            // A byte landing on the expiry edge is taken above, so it always wins.
            if (idle_cnt == EXPIRE_CNT) begin
              byte_idx        <= '0;
              shreg           <= '0;
              idle_cnt        <= '0;
              bus.busy        <= 1'b0;
              bus.timeout_err <= 1'b1;
              state           <= S_IDLE;
            end else begin
              idle_cnt <= idle_cnt + CNT_W'(1);
            end
          end
        end
        S_FULL: begin
          if (bus.byte_ready) bus.overflow_err <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
